// File: rtl/seg7_pattern_decoder.sv
// rtl/seg7_pattern_decoder.sv - debounced 7-segment glyph to 5-bit code decoder with one-entry output buffer
// Optional feature macro: SEG7_ERRCNT_EN adds the saturating err_count output.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [4:0] out_code,
    output logic       out_err,
`ifdef SEG7_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       overflow
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    seg_q;
    logic [6:0]    last_pat;
    logic          changed;
    logic          accept;
    logic          emit;
    logic          load;
    logic [5:0]    decoded;

    // Returns {err, code}; unknown glyphs map to code 1F with err set.
    function automatic logic [5:0] decode(input logic [6:0] pat);
        case (pat)
            7'h7E: decode = {1'b0, 5'h00};
            7'h30: decode = {1'b0, 5'h01};
            7'h6D: decode = {1'b0, 5'h02};
            7'h79: decode = {1'b0, 5'h03};
            7'h33: decode = {1'b0, 5'h04};
            7'h5B: decode = {1'b0, 5'h05};
            7'h5F: decode = {1'b0, 5'h06};
            7'h70: decode = {1'b0, 5'h07};
            7'h7F: decode = {1'b0, 5'h08};
            7'h7B: decode = {1'b0, 5'h09};
            7'h77: decode = {1'b0, 5'h0A};
            7'h1F: decode = {1'b0, 5'h0B};
            7'h4E: decode = {1'b0, 5'h0C};
            7'h3D: decode = {1'b0, 5'h0D};
            7'h4F: decode = {1'b0, 5'h0E};
            7'h47: decode = {1'b0, 5'h0F};
            7'h00: decode = {1'b0, 5'h10};
            7'h01: decode = {1'b0, 5'h11};
            default: decode = {1'b1, 5'h1F};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        changed = (seg_in != seg_q);
        case (state_q)
            SETTLE: begin
                if (changed) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        accept  = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (changed) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign decoded = decode(seg_q);
    assign emit    = accept && (seg_q != last_pat);
    assign load    = emit && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_in;
        end
    end

    // last_pat tracks every new glyph, even one lost to overflow, so it is not re-offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pat  <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_err   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (emit) begin
                last_pat <= seg_q;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_code  <= decoded[4:0];
                out_err   <= decoded[5];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (emit && out_valid && !out_ready) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SEG7_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (emit && decoded[5] && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// tb/tb_seg7_pattern_decoder.sv - directed self-checking bench for seg7_pattern_decoder
module tb_seg7_pattern_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [4:0] out_code;
    logic       out_err;
    logic       overflow;
`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    seg7_pattern_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_err   (out_err),
`ifdef SEG7_ERRCNT_EN
        .err_count (err_count),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new glyph at a negedge; result must appear after exactly 5 rising edges.
    task automatic expect_result(input logic [6:0] pat, input logic [4:0] code, input logic err);
        seg_in = pat;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("early_valid", {7'd0, out_valid}, 8'd0);
        end
        @(negedge clk);
        chk("valid", {7'd0, out_valid}, 8'd1);
        chk("code", {3'd0, out_code}, {3'd0, code});
        chk("err", {7'd0, out_err}, {7'd0, err});
    endtask

    task automatic hold_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, {7'd0, out_valid}, 8'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_in    = 7'h00;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_code", {3'd0, out_code}, 8'd0);
        chk("rst_err", {7'd0, out_err}, 8'd0);
        chk("rst_ovf", {7'd0, overflow}, 8'd0);
`ifdef SEG7_ERRCNT_EN
        chk("rst_errcnt", err_count, 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        hold_idle(20, "blank_after_reset");
        chk("blank_ovf", {7'd0, overflow}, 8'd0);

        expect_result(7'h7E, 5'h00, 1'b0);
        hold_idle(5, "pulse_7E");
        expect_result(7'h30, 5'h01, 1'b0);
        hold_idle(5, "pulse_30");

        expect_result(7'h6D, 5'h02, 1'b0);
        hold_idle(5, "pulse_6D");
        seg_in = 7'h7F;
        hold_idle(3, "glitch_7F");
        seg_in = 7'h6D;
        hold_idle(10, "return_6D");

        out_ready = 1'b0;
        expect_result(7'h4E, 5'h0C, 1'b0);
        seg_in = 7'h4F;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_code_0C", {3'd0, out_code}, 8'h0C);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("simul_valid", {7'd0, out_valid}, 8'd1);
        chk("simul_code", {3'd0, out_code}, 8'h0E);
        chk("simul_ovf", {7'd0, overflow}, 8'd0);
        @(negedge clk);
        chk("simul_drain", {7'd0, out_valid}, 8'd0);
        hold_idle(4, "after_4F");

        out_ready = 1'b0;
        expect_result(7'h79, 5'h03, 1'b0);
        repeat (3) @(negedge clk);
        seg_in = 7'h33;
        repeat (8) @(negedge clk);
        chk("ovf_valid", {7'd0, out_valid}, 8'd1);
        chk("ovf_code", {3'd0, out_code}, 8'h03);
        chk("ovf_flag", {7'd0, overflow}, 8'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ovf_drain", {7'd0, out_valid}, 8'd0);

        expect_result(7'h12, 5'h1F, 1'b1);
`ifdef SEG7_ERRCNT_EN
        chk("errcnt", err_count, 8'd1);
`endif
        hold_idle(4, "after_12");

        out_ready = 1'b0;
        expect_result(7'h7F, 5'h08, 1'b0);
        seg_in = 7'h4E;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'd0, out_valid}, 8'd0);
        chk("arst_code", {3'd0, out_code}, 8'd0);
        chk("arst_err", {7'd0, out_err}, 8'd0);
        chk("arst_ovf", {7'd0, overflow}, 8'd0);
`ifdef SEG7_ERRCNT_EN
        chk("arst_errcnt", err_count, 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_result(7'h4E, 5'h0C, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_pattern_decoder.md
# seg7_pattern_decoder

- Receive-side counterpart of the team's 5-bit-code → 7-segment encoder.
- Samples a 7-bit segment bus, filters out transient patterns, and decodes each newly stable glyph back to a 5-bit code.
- Presents each decoded code on a valid/ready output backed by a one-entry buffer.
- Used to check encoder outputs in-system and to read segment buses back into the datapath.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive unchanged samples required to accept a pattern; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- seg_in  input  7  segment bus, active-high; seg_in[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g
- out_ready  input  1  consumer accepts out_code this cycle
- out_valid  output  1  out_code/out_err hold a pending result
- out_code  output  5  decoded code
- out_err  output  1  pending result came from an undefined pattern
- overflow  output  1  sticky; a result was dropped
- err_count  output  8  saturating undefined-pattern count; present only with SEG7_ERRCNT_EN

## Operation
Decode table (seg_in hex → out_code):
- 7E→00, 30→01, 6D→02, 79→03, 33→04, 5B→05, 5F→06, 70→07, 7F→08, 7B→09, 77→0A, 1F→0B, 4E→0C, 3D→0D, 4F→0E, 47→0F.
- 00 (blank)→10; 01 (dash)→11.
- Any other pattern → out_code=1F, out_err=1.

State machine, states SETTLE and LOCKED:
- Input is registered into seg_q every edge.
- SETTLE:
  - cnt clears on any edge where seg_in≠seg_q.
  - Otherwise cnt increments.
  - When cnt reaches STABLE_CYCLES, the pattern is accepted and the FSM goes to LOCKED.
- LOCKED: stays until seg_in≠seg_q; then goes to SETTLE with cnt=0.

On acceptance:
- If seg_q equals last_pat, nothing is emitted.
- Otherwise last_pat←seg_q and the result is offered to the output buffer.

Output buffer:
- Load happens when the buffer is empty, or is being drained this edge (out_valid && out_ready).
- If the buffer is full and not draining, the result is dropped and overflow is set; last_pat is still updated.
- A drain without a simultaneous load clears out_valid.
- out_code/out_err are stable while out_valid=1 && out_ready=0.

Reset values (rst_n low, asynchronous):
- out_valid=0, out_code=00, out_err=0, overflow=0, err_count=0.
- FSM=SETTLE, cnt=0, seg_q=00, last_pat=00.
- Consequence: a blank bus after reset is never reported.
- Reset mid-settle or with a pending result discards all state immediately.

## Timing
- Latency: seg_in changes before edge 0 and is then held. Acceptance happens at edge STABLE_CYCLES; out_valid is high after that edge, i.e. STABLE_CYCLES+1 edges after the change.
- A glitch shorter than STABLE_CYCLES+1 edges is never reported. Returning to last_pat after a glitch emits nothing.
- Throughput: at most one result per STABLE_CYCLES+1 cycles. A consumer with out_ready tied high never causes overflow.
- Simultaneous drain and acceptance in the same edge: new result loaded, out_valid stays 1, no overflow.
- cnt width is clog2(STABLE_CYCLES+1); cnt saturates in LOCKED and never wraps.

## Configuration
- SEG7_ERRCNT_EN defined:
  - err_count port exists.
  - Increments on every accepted undefined pattern, including ones dropped by overflow.
  - Saturates at FF; cleared only by reset.
- SEG7_ERRCNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then hold seg_in=00 for 20 cycles → out_valid stays 0, overflow=0.
- STABLE_CYCLES=4, out_ready=1, drive 7E then 30, each held 10 cycles → out_code 00 then 01, each out_valid pulse beginning 5 edges after its change.
- Hold 6D stable, then a 3-cycle glitch to 7F, then back to 6D → exactly one result (02); no 08 emitted.
- out_ready=0, drive 79 then 33 (each held 8 cycles) → out_code=03 held, overflow=1; after out_ready=1 for one edge, out_valid=0.
- Drive 12 → out_code=1F, out_err=1; with SEG7_ERRCNT_EN, err_count=01.
- Assert rst_n low while a result is pending and mid-settle → all outputs 0 immediately, before the next clk edge.
